// File: rtl/key_scan_debounce.sv
// 4x4 key matrix scanner: walks one low column at a time, debounces the first
// closure it sees, reports it once, and holds the column until the key is released.
module key_scan_debounce #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] KEY_R,
   output logic [3:0] KEY_C,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {
      SCAN        = 2'd0,
      DEBOUNCE    = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_DEB = 2'd3
   } state_t;

   localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
   localparam logic [23:0] DEB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]  ROWS_IDLE  = 4'b1111;

   state_t      state_r, state_nx;
   logic [1:0]  col_r, col_nx;
   logic [15:0] dwell_r, dwell_nx;
   logic [23:0] deb_r, deb_nx;
   logic [3:0]  latch_r, latch_nx;
   logic [3:0]  code_nx;
   logic        valid_nx;
   logic [3:0]  sync1_r;
   logic [3:0]  rows_s;

   // Lowest-index low row wins when several rows are closed on one column.
   function automatic logic [1:0] low_row(input logic [3:0] rows);
      logic [1:0] idx;
      casez (rows)
         4'b???0: idx = 2'd0;
         4'b??01: idx = 2'd1;
         4'b?011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] col);
      return ~(4'b0001 << col);
   endfunction

   // Two-flop synchronizer for the row inputs; idle level is all rows high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 4'b1111;
         rows_s  <= 4'b1111;
      end else begin
         sync1_r <= KEY_R;
         rows_s  <= sync1_r;
      end
   end

   // Next-state and datapath decisions; counters stop at their terminal value.
   always_comb begin
      state_nx = state_r;
      col_nx   = col_r;
      dwell_nx = dwell_r;
      deb_nx   = deb_r;
      latch_nx = latch_r;
      code_nx  = key_code;
      valid_nx = 1'b0;
      case (state_r)
         SCAN: begin
            if (dwell_r >= DWELL_LAST) begin
               dwell_nx = 16'd0;
               if (rows_s != ROWS_IDLE) begin
                  latch_nx = rows_s;
                  deb_nx   = 24'd0;
                  state_nx = DEBOUNCE;
               end else begin
                  col_nx = col_r + 2'd1;
               end
            end else begin
               dwell_nx = dwell_r + 16'd1;
            end
         end
         DEBOUNCE: begin
            if (rows_s == latch_r) begin
               if (deb_r >= DEB_LAST) begin
                  state_nx = PRESSED;
                  code_nx  = {low_row(latch_r), col_r};
                  valid_nx = 1'b1;
               end else begin
                  deb_nx = deb_r + 24'd1;
               end
            end else begin
               state_nx = SCAN;
               col_nx   = col_r + 2'd1;
               dwell_nx = 16'd0;
            end
         end
         PRESSED: begin
            if (rows_s == ROWS_IDLE) begin
               state_nx = RELEASE_DEB;
               deb_nx   = 24'd0;
            end else begin
               state_nx = PRESSED;
            end
         end
         RELEASE_DEB: begin
            // Any closure during release debounce means the key is still down.
            if (rows_s == ROWS_IDLE) begin
               if (deb_r >= DEB_LAST) begin
                  state_nx = SCAN;
                  col_nx   = col_r + 2'd1;
                  dwell_nx = 16'd0;
               end else begin
                  deb_nx = deb_r + 24'd1;
               end
            end else begin
               state_nx = PRESSED;
            end
         end
         default: begin
            state_nx = SCAN;
            col_nx   = 2'd0;
            dwell_nx = 16'd0;
            deb_nx   = 24'd0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= SCAN;
         col_r     <= 2'd0;
         dwell_r   <= 16'd0;
         deb_r     <= 24'd0;
         latch_r   <= 4'b1111;
         KEY_C     <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state_r   <= state_nx;
         col_r     <= col_nx;
         dwell_r   <= dwell_nx;
         deb_r     <= deb_nx;
         latch_r   <= latch_nx;
         KEY_C     <= col_drive(col_nx);
         key_code  <= code_nx;
         key_valid <= valid_nx;
         key_held  <= (state_nx == PRESSED) || (state_nx == RELEASE_DEB);
      end
   end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with SCAN_DIV=4, DEBOUNCE_CYCLES=8; a key
// matrix model derives KEY_R from the pressed-key set and the driven column.
module tb_key_scan_debounce;

   logic        clk;
   logic        rst_n;
   logic [3:0]  KEY_R;
   logic [3:0]  KEY_C;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;
   int b2b         = 0;
   logic prev_valid = 1'b0;

   key_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .KEY_R     (KEY_R),
      .KEY_C     (KEY_C),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // keys[code] closes row code/4 onto column code%4.
   assign KEY_R[0] = ~|(keys[3:0]   & ~KEY_C);
   assign KEY_R[1] = ~|(keys[7:4]   & ~KEY_C);
   assign KEY_R[2] = ~|(keys[11:8]  & ~KEY_C);
   assign KEY_R[3] = ~|(keys[15:12] & ~KEY_C);

   always @(posedge clk) begin
      if (key_valid) pulses <= pulses + 1;
      if (key_valid && prev_valid) b2b <= b2b + 1;
      prev_valid <= key_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Land on the first negedge of a fresh dwell on the column driving pattern tgt.
   task automatic wait_col_start(input string tag, input logic [3:0] tgt);
      int n;
      n = 0;
      while (KEY_C === tgt && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (KEY_C !== tgt && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(tag, KEY_C, tgt);
   endtask

   initial begin
      rst_n = 1'b0;
      keys  = 16'h0000;
      tick(3);
      check("rst_kc", KEY_C, 4'b1110);
      check("rst_code", key_code, 4'h0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_held", key_held, 1'b0);

      // Idle scanning: each column driven for 4 cycles.
      rst_n = 1'b1;
      tick(3);  check("scan_c0", KEY_C, 4'b1110);
      tick(1);  check("scan_c1", KEY_C, 4'b1101);
      tick(4);  check("scan_c2", KEY_C, 4'b1011);
      tick(4);  check("scan_c3", KEY_C, 4'b0111);
      tick(4);  check("scan_wrap", KEY_C, 4'b1110);
      check("idle_pulses", pulses, 0);

      // Key 9 held across reset release: sampled on col1 dwell end, strobe 9 cycles later.
      rst_n = 1'b0;
      keys[9] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(15); check("k9_pre", key_valid, 1'b0);
      check("k9_pre_held", key_held, 1'b0);
      tick(1);  check("k9_strobe", key_valid, 1'b1);
      check("k9_code", key_code, 4'h9);
      check("k9_held", key_held, 1'b1);
      tick(1);  check("k9_post", key_valid, 1'b0);
      tick(33); check("k9_hold", key_held, 1'b1);
      check("k9_one_pulse", pulses, 1);
      keys[9] = 1'b0;
      tick(10); check("k9_rel_held", key_held, 1'b1);
      tick(1);  check("k9_rel_done", key_held, 1'b0);
      check("k9_next_col", KEY_C, 4'b1011);
      check("k9_code_keep", key_code, 4'h9);

      // Key 3 bouncing (low 3 / high 2), then stable.
      repeat (6) begin
         keys[3] = 1'b1;
         tick(3);
         keys[3] = 1'b0;
         tick(2);
      end
      check("k3_bounce", pulses, 1);
      keys[3] = 1'b1;
      tick(40);
      check("k3_pulses", pulses, 2);
      check("k3_code", key_code, 4'h3);
      check("k3_held", key_held, 1'b1);
      keys[3] = 1'b0;
      tick(15);
      check("k3_released", key_held, 1'b0);

      // 5-cycle glitch on key 4 from the start of a column-0 dwell.
      wait_col_start("g4_align", 4'b1110);
      keys[4] = 1'b1;
      tick(5);
      keys[4] = 1'b0;
      tick(2);  check("g4_col_held", KEY_C, 4'b1110);
      tick(1);  check("g4_resume", KEY_C, 4'b1101);
      check("g4_pulses", pulses, 2);
      check("g4_code", key_code, 4'h3);
      check("g4_held", key_held, 1'b0);

      // Key 5 held; key F pressed meanwhile is ignored; short release glitch.
      keys[5] = 1'b1;
      for (int n = 0; n < 40 && key_held !== 1'b1; n++) @(negedge clk);
      check("k5_held", key_held, 1'b1);
      tick(2);
      check("k5_pulses", pulses, 3);
      check("k5_code", key_code, 4'h5);
      keys[15] = 1'b1;
      tick(10);
      keys[15] = 1'b0;
      tick(3);
      check("kF_ignored", pulses, 3);
      check("kF_code", key_code, 4'h5);
      keys[5] = 1'b0;
      tick(3);
      keys[5] = 1'b1;
      for (int n = 0; n < 10; n++) begin
         check("k5_glitch_held", key_held, 1'b1);
         @(negedge clk);
      end
      keys[5] = 1'b0;
      tick(15);
      check("k5_released", key_held, 1'b0);
      check("k5_total", pulses, 3);

      // Reset in the middle of debouncing key A, then re-detection.
      wait_col_start("kA_align", 4'b1011);
      keys[10] = 1'b1;
      tick(6);
      rst_n = 1'b0;
      #1;
      check("kA_rst_kc", KEY_C, 4'b1110);
      check("kA_rst_code", key_code, 4'h0);
      check("kA_rst_valid", key_valid, 1'b0);
      check("kA_rst_held", key_held, 1'b0);
      tick(2);
      check("kA_no_pulse", pulses, 3);
      rst_n = 1'b1;
      tick(19); check("kA_pre", key_valid, 1'b0);
      tick(1);  check("kA_strobe", key_valid, 1'b1);
      check("kA_code", key_code, 4'hA);
      tick(1);  check("kA_post", key_valid, 1'b0);
      keys[10] = 1'b0;
      tick(15);
      check("kA_total", pulses, 4);
      check("no_b2b", b2b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_scan_debounce.md
KEY_SCAN_DEBOUNCE -- requirements
Module: key_scan_debounce

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each column is driven during scanning; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000, giving the consecutive stable cycles required for press and for release; legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port KEY_R, input, 4 bits: matrix row inputs, pulled up, low = key closed on the driven column.
REQ-006 SHALL have port KEY_C, output, 4 bits: column drive, exactly one bit low at all times.
REQ-007 SHALL have port key_code, output, 4 bits: code of last accepted key, = row_index*4 + col_index (bit indices of KEY_R / low KEY_C bit).
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle strobe, high when key_code has just been updated for a new accepted press.
REQ-009 SHALL have port key_held, output, 1 bit: high while an accepted key is still pressed (PRESSED or RELEASE_DEB states).

Function
REQ-010 SHALL pass KEY_R through a 2-flop synchronizer; all decisions use the synchronized value (rows_s).
REQ-011 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE_DEB.
REQ-012 SCAN: drive column c low for SCAN_DIV cycles, then advance c = c+1 mod 4 (3 wraps to 0); KEY_C = ~(1<<c).
REQ-013 SCAN: rows_s sampled only on the last dwell cycle of a column; if rows_s != 4'b1111, latch rows_s and c, reset debounce counter, go to DEBOUNCE with column held; else advance column.
REQ-014 DEBOUNCE: counter increments each cycle rows_s equals latched pattern; on mismatch return to SCAN, advance to next column, no strobe.
REQ-015 DEBOUNCE: when counter reaches DEBOUNCE_CYCLES, go to PRESSED; in the same cycle key_code updates and key_valid = 1 for exactly that cycle.
REQ-016 Multiple rows low on one column: lowest-index low row gives row_index; the full 4-bit pattern is still what must stay stable.
REQ-017 PRESSED: column held; key_held = 1; no further strobes; when rows_s == 4'b1111 go to RELEASE_DEB with counter cleared.
REQ-018 RELEASE_DEB: counter increments while rows_s == 4'b1111; any low row returns to PRESSED without strobe; counter reaching DEBOUNCE_CYCLES goes to SCAN at next column, key_held = 0.
REQ-019 Holding a key SHALL produce exactly one key_valid pulse irrespective of hold length; autorepeat not supported.
REQ-020 Pressing a second key while one is held (any column) SHALL be ignored until the first is release-debounced.
REQ-021 key_code SHALL retain its value between accepted presses; key_valid never high in two consecutive cycles.
REQ-022 Counters SHALL saturate, never wrap; column/dwell counters sized for max parameter values.
REQ-023 Latency: press stable from first sample to strobe = DEBOUNCE_CYCLES+1 cycles after the SCAN sample cycle, plus 2 synchronizer cycles from pin.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force: state SCAN, column 0, KEY_C = 4'b1110, dwell and debounce counters 0, synchronizer flops 4'b1111, key_code = 4'h0, key_valid = 0, key_held = 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard the pending key; after release, a still-held key is re-detected from SCAN as a new press.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset released, no keys -> KEY_C cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never high.
REQ-027 Key row 2/col 1 held 50 cycles -> exactly one key_valid, key_code = 4'h9, key_held high until 8 cycles after release +sync.
REQ-028 Key row 0/col 3 bouncing (low 3, high 2, repeated) then stable 20 cycles -> no strobe during bounce; one strobe, key_code = 4'h3.
REQ-029 Glitch low for 5 cycles (< 8) on row 1 col 0 -> no strobe, key_code unchanged, scanning resumes at column 1.
REQ-030 Key 4'h5 held, key 4'hF pressed and released during hold, then 4'h5 released -> single strobe for 4'h5 only; release glitch of 3 cycles keeps key_held high.
REQ-031 rst_n pulsed low during DEBOUNCE of key 4'hA -> outputs at reset values immediately, no strobe; key still held after reset -> new strobe with 4'hA.
